// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO map constants for the dmem responder.
package dmem_pkg;
  localparam logic [15:0] MMIO_BASE = 16'hFFFF;
  typedef enum logic [1:0] {
    TXDATA   = 2'd0,
    STATUS   = 2'd1,
    CYCLE    = 2'd2,
    RESERVED = 2'd3
  } mmioOffset_t;
  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: count-based circular FIFO; a push while full is accepted only if a pop frees a slot on the same edge.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic pushOk, popOk;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign popOk = pop && !empty;
  assign pushOk = push && (!full || popOk);
  assign dout = empty ? '0 : mem[rdPtr];
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk) rdPtr <= rdPtr + 1'b1;
      count <= count + (PW+1)'(pushOk) - (PW+1)'(popOk);
    end
  end
  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr] <= din;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus MMIO window (TX FIFO, STATUS, CYCLE) on the processor dmem port.
// Define DMEM_CYCLE_COUNTER_EN to implement the free-running CYCLE register.
import dmem_pkg::*;
module dmem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic        access_en,
  output logic [31:0] q_dmem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] mem [DEPTH_WORDS];
  logic isMmio, isRam, we, txPush, txPop, txDrop, fifoFull, fifoEmpty, overflow;
  mmioOffset_t offset;
  logic [CW-1:0] fifoCount;
  logic [7:0] lastByte;
  logic [31:0] cycleVal, statusWord, rdData;
  assign isMmio = address_dmem[31:16] == MMIO_BASE;
  assign isRam = !isMmio && (address_dmem < 32'(DEPTH_WORDS));
  assign offset = mmioOffset_t'(address_dmem[1:0]);
  assign we = wren && access_en;
  assign txPush = we && isMmio && offset == TXDATA;
  assign txPop = tx_valid && tx_ready;
  assign txDrop = txPush && fifoFull && !txPop;
  assign tx_valid = fifoCount != '0;
  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) txFifo (
    .clock (clock),
    .reset (reset),
    .push  (txPush),
    .pop   (txPop),
    .din   (data[7:0]),
    .dout  (tx_data),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );
  always_ff @(posedge clock) begin
    if (we && isRam) mem[address_dmem[AW-1:0]] <= data;
  end
`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycleCnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycleCnt <= '0;
    else cycleCnt <= (we && isMmio && offset == CYCLE) ? data : cycleCnt + 32'd1;
  end
  assign cycleVal = cycleCnt;
`else
  assign cycleVal = '0;
`endif
  // Reads see pre-edge state; the RAM array is read before this edge's write lands.
  always_comb begin
    statusWord = '0;
    statusWord[ST_EMPTY] = fifoEmpty;
    statusWord[ST_FULL] = fifoFull;
    statusWord[ST_OVERFLOW] = overflow;
    rdData = isMmio ? (offset == TXDATA ? {24'b0, lastByte} :
                       offset == STATUS ? statusWord :
                       offset == CYCLE  ? cycleVal : '0)
           : isRam ? mem[address_dmem[AW-1:0]] : '0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem <= '0;
      overflow <= 1'b0;
      lastByte <= '0;
    end else begin
      q_dmem <= rdData;
      if (txPush && !txDrop) lastByte <= data[7:0];
      overflow <= txDrop ? 1'b1
                : (we && isMmio && offset == STATUS && data[ST_OVERFLOW]) ? 1'b0 : overflow;
    end
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the processor's dmem port (`address_dmem`, `data`, `wren` → `q_dmem`). Word-addressed RAM plus a small MMIO window holding a byte-transmit FIFO with a valid/ready output stream, a status register and a free-running cycle counter. Sits in the wrapper between the processor core and the board I/O, replacing the bare dmem instance.

## Interface
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `address_dmem` in 32: word address from the processor.
- `data` in 32: store data.
- `wren` in 1: store request.
- `access_en` in 1: processor pipeline advancing this cycle (its latch write enable). Writes and side effects are committed only when this is 1.
- `q_dmem` out 32: load data, registered.
- `tx_data` out 8: transmit byte.
- `tx_valid` out 1: FIFO head valid.
- `tx_ready` in 1: sink accepts the byte.

## Operation
- Decode on `address_dmem[31:16]`:
  - `16'hFFFF` selects MMIO. Offset is `[1:0]`; offset 3 reads 0 and ignores writes.
  - Otherwise, RAM if `address_dmem < DEPTH_WORDS`.
  - Anything else is out of range: reads 0, writes ignored.
- RAM: write when `wren && access_en`. A read of the same address in the same edge returns the old contents (read-first). Contents are not reset.
- MMIO offset 0, TXDATA:
  - Write pushes `data[7:0]`.
  - Push while full (after same-edge pop accounting) drops the byte and sets sticky `overflow`.
  - Reads return `{24'b0, last pushed byte}`.
- MMIO offset 1, STATUS:
  - Read: `{29'b0, overflow, full, empty}`.
  - Write with `data[2]=1` clears `overflow`. Other bits are ignored.
- MMIO offset 2, CYCLE:
  - 32-bit counter, +1 every clock, wraps `FFFF_FFFF` → 0.
  - Write loads `data`; the next edge yields `data+1`.
- Reads have no side effects. `access_en` gates writes only; repeated `wren` during a processor stall therefore pushes exactly once.
- TX stream:
  - Pop when `tx_valid && tx_ready`.
  - `tx_data` is the FIFO head and is held stable while `tx_valid && !tx_ready`.
  - Push and pop on the same edge when full: push accepted, count unchanged, no overflow.
  - Push into an empty FIFO: no bypass; `tx_valid` rises the following cycle.
- Reset (async assert, sync-style release) sets:
  - `q_dmem=0`, `tx_valid=0`, `tx_data=0`
  - FIFO empty, `overflow=0`, `CYCLE=0`
  - Last-pushed byte = 0

## Timing
- The processor drives address, data and `wren` off the falling edge. The responder samples on the rising edge, and `q_dmem` is valid from that rising edge until the next one. The processor latches it at the following falling edge, so there is no added load latency.
- STATUS and CYCLE reads return the value before any update made on the same edge.
- FIFO count is in range `0..FIFO_DEPTH`. Pointers wrap modulo `FIFO_DEPTH`; `full` and `empty` are derived from the count.

## Configuration
- `DMEM_CYCLE_COUNTER_EN`:
  - Defined: CYCLE register implemented as above.
  - Undefined: no counter flops; offset 2 reads 0 and ignores writes.

## Structure
- Shared package `dmem_pkg`:
  - MMIO base `16'hFFFF`
  - Offset constants `TXDATA=0`, `STATUS=1`, `CYCLE=2`
  - STATUS bit positions
- Sub-module `tx_fifo`, parameterised by depth and width, with push/pop/full/empty/count.
- Decode, RAM and registers live in `dmem_responder`.

## Test plan
- Store `32'hDEADBEEF` to address 5, then load 5 → `q_dmem=32'hDEADBEEF` one rising edge later. Load 5000 (out of range) → 0, with no RAM side effect.
- With `tx_ready=0`, push 9 bytes `0x41..0x49` into a depth-8 FIFO → STATUS = `3'b110`, eight bytes held. Then `tx_ready=1` → `0x41..0x48` appear in order and `0x49` is dropped. Writing STATUS with `data[2]=1` → STATUS=`3'b001`.
- Full FIFO, push and `tx_ready=1` on the same edge → push accepted, count stays 8, `overflow` stays 0.
- `wren=1` held on TXDATA for 4 cycles with `access_en` high for only 1 → exactly one byte enqueued.
- With the macro defined: write CYCLE=100, read it 3 edges later → 103. Write `FFFF_FFFF` → it reads 0 after one edge. With the macro undefined → CYCLE reads 0.
- Drive `reset` low mid-stream with 3 bytes queued and `tx_valid=1` → `tx_valid`, `q_dmem`, count and `overflow` go to 0 immediately, without waiting for a clock; after release the first push is output correctly.
